// File: rtl/mc_ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle sequencing controller.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_REL   = 2'd1,
    PC_JALR  = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/mc_seq_ctrl_op_classify.sv
// Combinational opcode classifier: legality plus the classes the sequencer branches on.
module op_classify
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr
);

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  assign legal = is_load || is_store || is_branch || is_jal || is_jalr ||
                 (opcode == OP_R) || (opcode == OP_IMM) ||
                 (opcode == OP_LUI) || (opcode == OP_AUIPC);

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB timing, memory handshakes,
// trap detection (illegal opcode, memory timeout) and retired-instruction count.
module mc_seq_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t                 state_q, state_d;
  trap_cause_t            cause_q, cause_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   legal, is_load, is_store, is_branch, is_jal, is_jalr;
  logic                   timeout_hit, waiting;

  op_classify u_op_classify (
    .opcode    (opcode),
    .legal     (legal),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr)
  );

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_PLUS4;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? PC_REL : PC_PLUS4;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        if (is_jal)       pc_src = PC_REL;
        else if (is_jalr) pc_src = PC_JALR;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Strobes are suppressed during the reset cycle itself, before the state register clears.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
      pc_src   = PC_PLUS4;
    end
  end

  always_comb begin
    waiting = ((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready);
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + WAIT_W'(1);
    else                    wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= CAUSE_NONE;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      if (pc_we) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign state_o    = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: per-cycle expected control vectors queued at drive time,
// popped and compared on the falling edge.
module tb_mc_seq_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, trap;
  logic [1:0]  pc_src, trap_cause;
  logic [2:0]  state_o;
  logic [31:0] instret;

  mc_seq_ctrl #(.MEM_TIMEOUT(16), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .reg_we(reg_we),
    .pc_we(pc_we), .pc_src(pc_src), .trap(trap), .trap_cause(trap_cause),
    .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  // {state, imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, pc_src, trap, cause}
  typedef struct {
    string       tag;
    logic [13:0] ctl;
    logic [31:0] ret;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         cur;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_ret = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ev(input logic [2:0] st, input logic ireq, input logic dreq,
                                     input logic dwe, input logic irwe, input logic rwe,
                                     input logic pwe, input logic [1:0] src, input logic trp,
                                     input logic [1:0] cause);
    return {st, ireq, dreq, dwe, irwe, rwe, pwe, src, trp, cause};
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      chk({cur.tag, "/ctl"}, {18'd0, state_o, imem_req, dmem_req, dmem_we, ir_we, reg_we,
                              pc_we, pc_src, trap, trap_cause}, {18'd0, cur.ctl});
      chk({cur.tag, "/instret"}, instret, cur.ret);
    end
  end

  task automatic step(input string tag, input logic [6:0] op, input logic br, input logic ir,
                      input logic dr, input logic r, input logic [13:0] e);
    @(posedge clk);
    #1;
    opcode = op; branch_taken = br; imem_ready = ir; dmem_ready = dr; rst = r;
    sb_q.push_back('{tag: tag, ctl: e, ret: exp_ret});
    if (r) exp_ret = 0;
    else if (e[5]) exp_ret++;
  endtask

  task automatic rst_seq(input string tag, input logic [2:0] st, input logic trp,
                         input logic [1:0] cause);
    step({tag, "_r0"}, OP_IMM, 1'b0, 1'b1, 1'b1, 1'b1, ev(st, 0,0,0,0,0,0, 2'd0, trp, cause));
    step({tag, "_r1"}, OP_IMM, 1'b0, 1'b1, 1'b1, 1'b1, ev(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
  endtask

  task automatic front(input string tag, input logic [6:0] op);
    step({tag, "_F"}, op, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd0, 1,0,0,1,0,0, 2'd0, 0, 2'd0));
    step({tag, "_D"}, op, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd1, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
  endtask

  task automatic run_wb(input string tag, input logic [6:0] op, input logic [1:0] src);
    front(tag, op);
    step({tag, "_X"}, op, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd2, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
    step({tag, "_W"}, op, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd4, 0,0,0,0,1,1, src, 0, 2'd0));
  endtask

  task automatic run_load(input string tag, input int unsigned delay);
    front(tag, OP_LOAD);
    step({tag, "_X"}, OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd2, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
    for (int unsigned i = 0; i < delay; i++)
      step({tag, "_Mw"}, OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd3, 0,1,0,0,0,0, 2'd0, 0, 2'd0));
    step({tag, "_M"}, OP_LOAD, 1'b0, 1'b1, 1'b1, 1'b0, ev(3'd3, 0,1,0,0,0,0, 2'd0, 0, 2'd0));
    step({tag, "_W"}, OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd4, 0,0,0,0,1,1, 2'd0, 0, 2'd0));
  endtask

  task automatic run_store(input string tag);
    front(tag, OP_STORE);
    step({tag, "_X"}, OP_STORE, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd2, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
    step({tag, "_M"}, OP_STORE, 1'b0, 1'b1, 1'b1, 1'b0, ev(3'd3, 0,1,1,0,0,1, 2'd0, 0, 2'd0));
  endtask

  task automatic run_branch(input string tag, input logic taken);
    front(tag, OP_BRANCH);
    step({tag, "_X"}, OP_BRANCH, taken, 1'b1, 1'b0, 1'b0,
         ev(3'd2, 0,0,0,0,0,1, taken ? 2'd1 : 2'd0, 0, 2'd0));
  endtask

  task automatic idle_fetch(input string tag);
    step(tag, OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, ev(3'd0, 1,0,0,0,0,0, 2'd0, 0, 2'd0));
  endtask

  initial begin
    rst = 1'b1; opcode = OP_IMM; branch_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;

    // Reset cycle with imem_ready high: state FETCH, no strobes
    step("reset", OP_IMM, 1'b0, 1'b1, 1'b0, 1'b1, ev(3'd0, 0,0,0,0,0,0, 2'd0, 0, 2'd0));

    run_wb("addi", OP_IMM, 2'd0);
    idle_fetch("addi_done");

    rst_seq("ld", 3'd0, 1'b0, 2'd0);
    run_load("load3", 3);
    idle_fetch("load_done");

    rst_seq("stbr", 3'd0, 1'b0, 2'd0);
    run_store("store");
    run_branch("beq_t", 1'b1);
    idle_fetch("stbr_done");
    run_branch("beq_nt", 1'b0);
    run_wb("rtype", OP_R, 2'd0);
    run_wb("lui", OP_LUI, 2'd0);
    run_wb("auipc", OP_AUIPC, 2'd0);
    run_wb("jal", OP_JAL, 2'd1);
    run_wb("jalr", OP_JALR, 2'd2);

    // Illegal opcode: trap is terminal even with both memories ready
    step("ill_F", 7'b0000000, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd0, 1,0,0,1,0,0, 2'd0, 0, 2'd0));
    step("ill_D", 7'b0000000, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd1, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
    for (int unsigned i = 0; i < 20; i++)
      step("ill_T", 7'b0000000, 1'b1, 1'b1, 1'b1, 1'b0, ev(3'd5, 0,0,0,0,0,0, 2'd0, 1, 2'd1));
    rst_seq("ill", 3'd5, 1'b1, 2'd1);
    idle_fetch("ill_after");

    // Fetch timeout: 16 waiting cycles, then TRAP cause 2
    rst_seq("ito", 3'd0, 1'b0, 2'd0);
    for (int unsigned i = 0; i < 16; i++) idle_fetch("ito_wait");
    step("ito_T", OP_IMM, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd5, 0,0,0,0,0,0, 2'd0, 1, 2'd2));
    rst_seq("ito", 3'd5, 1'b1, 2'd2);

    // Ready on the last allowed cycle: completion wins
    for (int unsigned i = 0; i < 15; i++) idle_fetch("edge_wait");
    run_wb("edge", OP_IMM, 2'd0);

    // Data timeout: 16 waiting cycles in MEM, then TRAP cause 3
    front("dto", OP_LOAD);
    step("dto_X", OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd2, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
    for (int unsigned i = 0; i < 16; i++)
      step("dto_Mw", OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd3, 0,1,0,0,0,0, 2'd0, 0, 2'd0));
    step("dto_T", OP_LOAD, 1'b0, 1'b1, 1'b1, 1'b0, ev(3'd5, 0,0,0,0,0,0, 2'd0, 1, 2'd3));
    rst_seq("dto", 3'd5, 1'b1, 2'd3);

    // Reset mid-MEM drops dmem_req immediately and returns to FETCH
    front("rmem", OP_LOAD);
    step("rmem_X", OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd2, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
    step("rmem_Mw", OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, ev(3'd3, 0,1,0,0,0,0, 2'd0, 0, 2'd0));
    step("rmem_R", OP_LOAD, 1'b0, 1'b1, 1'b0, 1'b1, ev(3'd3, 0,0,0,0,0,0, 2'd0, 0, 2'd0));
    run_load("rmem_ld", 0);
    idle_fetch("final");

    @(posedge clk);
    @(posedge clk);
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencing controller for the RV32 core.
- Steps the shared datapath (instruction register, register file, ALU, PC, data memory port) through FETCH/DECODE/EXEC/MEM/WB.
- Issues request/ready handshakes to instruction and data memory, and generates PC/IR/regfile write strobes.
- Detects illegal opcodes and memory timeouts, and counts retired instructions.
- Sits beside the combinational instruction decoder; that decoder supplies ALU/mux selects, and this block supplies timing.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory request may wait for ready; 0 disables the timeout.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  7  IR[6:0]; stable from DECODE until the instruction retires
- branch_taken  in  1  ALU compare result, valid in EXEC
- imem_ready  in  1  instruction memory accepts/returns this cycle
- dmem_ready  in  1  data memory completes this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (store); only meaningful with dmem_req
- ir_we  out  1  latch fetched instruction
- reg_we  out  1  register file write
- pc_we  out  1  PC update
- pc_src  out  2  0 PLUS4, 1 PC+imm (branch/jal), 2 rs1+imm (jalr)
- trap  out  1  core halted in TRAP
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
- state_o  out  3  current state, for debug
- instret  out  INSTRET_W  retired instruction count

Behaviour:
- Reset
  - rst=1: state←FETCH, wait counter←0, instret←0, trap_cause←0.
  - All strobe outputs are 0 while rst=1, including in the reset cycle.
  - Reset is honoured in every state, including mid-handshake and TRAP.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Strobes are combinational from state and inputs. The state change is registered.
- FETCH
  - imem_req=1.
  - imem_ready=1: ir_we=1 the same cycle, then go to DECODE.
  - Otherwise hold.
- DECODE
  - One cycle. Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Illegal opcode → TRAP, cause 1.
  - Legal opcode → EXEC.
- EXEC (one cycle)
  - Load/store → MEM.
  - Branch: pc_we=1, pc_src = branch_taken ? 1 : 0, instret+1, then FETCH.
  - All others → WB.
- MEM
  - dmem_req=1. dmem_we=1 iff the opcode is store.
  - Hold until dmem_ready.
  - Load completes → WB.
  - Store completes: pc_we=1, pc_src=0, instret+1, then FETCH.
- WB
  - reg_we=1, pc_we=1, instret+1, then FETCH.
  - pc_src: jal=1, jalr=2, otherwise 0.
- TRAP
  - Terminal: all strobes 0, trap=1, trap_cause held. Exits only via rst.
- Latency with zero-wait memory:
  - ALU/lui/auipc/jal/jalr: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Timeout counter
  - Cleared on every state entry.
  - Increments each cycle in FETCH/MEM while ready=0.
  - Ready=0 while the counter equals MEM_TIMEOUT-1 → TRAP next cycle, cause 2 (FETCH) or 3 (MEM).
  - Ready=1 in that same cycle: completion wins, no trap.
- instret
  - Increments by exactly 1 per retired instruction, in the cycle pc_we=1.
  - Wraps modulo 2^INSTRET_W.
- Invariants
  - pc_we, ir_we and reg_we are never high in TRAP.
  - imem_req and dmem_req are never both high.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum.
  - pc_src_t enum.
  - trap_cause_t enum.
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
- Sub-module op_classify (combinational) maps opcode → {legal, is_load, is_store, is_branch, is_jal, is_jalr}.

Test Plan:
- Reset then addi (0010011), imem_ready=1 always: states 0→1→2→4→0. ir_we in cycle 1, reg_we+pc_we in cycle 4, pc_src=0, instret=1.
- Load (0000011) with dmem_ready delayed 3 cycles: MEM held 4 cycles with dmem_req=1, dmem_we=0, then WB reg_we=1; total 8 cycles, instret=1.
- Store then beq taken (1100011, branch_taken=1):
  - Store: dmem_we=1 in MEM, reg_we never asserted.
  - Branch: pc_we=1 with pc_src=1 in EXEC, instret=2.
- Illegal opcode 0000000: DECODE→TRAP; trap=1, trap_cause=1. Strobes stay 0 for 20 cycles despite imem_ready=1. rst=1 returns to FETCH with instret=0.
- MEM_TIMEOUT=16:
  - imem_ready=0 for 16 cycles → TRAP, cause 2.
  - Separate run with imem_ready=1 on the 16th cycle → DECODE, no trap.
- jalr (1100111): WB asserts pc_src=2, reg_we=1.
- rst asserted mid-MEM while dmem_req=1: next cycle state=FETCH and dmem_req=0.
